// File: rtl/laplace_stream_if.sv
// Stream bundle for laplace_stream: pixel input handshake, per-pixel mode and filtered output handshake.
// master = the environment (image loader upstream, writer downstream); slave = the filter itself.
// Ports: mode/in_valid/in_pixel/in_ready on the input side; out_valid/out_ready/out_pixel/out_last on the output side.
interface laplace_stream_if #(
    parameter int PIX_W = 8
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    logic             out_last;

    modport master (
        output mode, in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_last
    );

    modport slave (
        input  mode, in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_last
    );
endinterface

// File: rtl/laplace_stream.sv
// Streaming approximate Laplacian over a raster pixel stream; emits the (IMG_W-2)x(IMG_H-2) interior in raster order.
// Latency: 1 cycle from the edge that accepts pixel (r,c), r>=2 && c>=2, to out_valid for centre (r-1,c-1).
// Backpressure: in_ready = !out_valid || out_ready; output holds while stalled; 1 pixel/cycle when unstalled.
//
// Ports: clk, rst (synchronous, active-high), s (laplace_stream_if.slave: mode, in_valid/in_ready/in_pixel,
//        out_valid/out_ready/out_pixel/out_last).
// Build option: define LAPLACE_DIAG_EN for the 8-neighbour kernel (8*e - sum of 8 neighbours);
//        the default build uses the 5-point kernel (4*e - up - down - left - right).
module laplace_stream #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    laplace_stream_if.slave  s
);

    localparam int CW = $clog2(IMG_W);
    localparam int RH = $clog2(IMG_H);
`ifdef LAPLACE_DIAG_EN
    localparam int RW  = PIX_W + 4;
    localparam int KSH = 3;
`else
    localparam int RW  = PIX_W + 3;
    localparam int KSH = 2;
`endif
    localparam logic [PIX_W-1:0] PMAX = '1;

    logic [CW-1:0] col;
    logic [RH-1:0] row;

    // lb0 holds row r-1, lb1 holds row r-2 at each column (async read, sync write).
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];

    // Stored window columns: cm_* is column c-1 (centre), cl_* is column c-2 (left).
    // The incoming column {lb1[c], lb0[c], in_pixel} completes the 3x3 window combinationally,
    // which is what gives a single cycle of latency.
    logic [PIX_W-1:0] cm_top, cm_mid, cm_bot;
    logic [PIX_W-1:0] cl_mid;
`ifdef LAPLACE_DIAG_EN
    logic [PIX_W-1:0] cl_top, cl_bot;
`endif

    logic [PIX_W-1:0] up_in, mid_in;
    logic             accept, emit, col_last, row_last;

    logic        [RW-1:0] nsum, ctr, mag;
    logic signed [RW-1:0] raw;
    logic [PIX_W-1:0]     res;

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign accept     = s.in_valid && s.in_ready;
    assign col_last   = (col == CW'(IMG_W - 1));
    assign row_last   = (row == RH'(IMG_H - 1));
    // The r>=2 / c>=2 gate also guarantees no window spanning a row or frame boundary is ever emitted.
    assign emit       = accept && (row >= RH'(2)) && (col >= CW'(2));

    assign up_in  = lb1[col];
    assign mid_in = lb0[col];

    always_comb begin
        nsum = RW'(cm_top) + RW'(cm_bot) + RW'(cl_mid) + RW'(mid_in);
`ifdef LAPLACE_DIAG_EN
        nsum = nsum + RW'(cl_top) + RW'(cl_bot) + RW'(up_in) + RW'(s.in_pixel);
`endif
        ctr = RW'(cm_mid) << KSH;
        raw = $signed(ctr - nsum);
        mag = raw;
        if (raw[RW-1]) begin
            mag = s.mode ? RW'(-raw) : '0;
        end
        res = (mag > RW'(PMAX)) ? PMAX : mag[PIX_W-1:0];
    end

    // Control and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            s.out_valid <= 1'b0;
            s.out_pixel <= '0;
            s.out_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RH'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            // emit implies accept implies the current output is gone or leaving this edge,
            // so loading here never overwrites an unconsumed result.
            if (emit) begin
                s.out_valid <= 1'b1;
                s.out_pixel <= res;
                s.out_last  <= row_last && col_last;
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end

    // Datapath storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= s.in_pixel;
            cm_top   <= up_in;
            cm_mid   <= mid_in;
            cm_bot   <= s.in_pixel;
            cl_mid   <= cm_mid;
`ifdef LAPLACE_DIAG_EN
            cl_top   <= cm_top;
            cl_bot   <= cm_bot;
`endif
        end
    end

endmodule

// File: tb/tb_laplace_stream.sv
// Self-checking bench for laplace_stream on an 8x8 image: reference model computes the interior from the frame.
// Output compared against the model on every transfer; handshake and stall stability checked every cycle.
// Directed frames: flat, impulse (both modes), random backpressure, mid-frame reset, back-to-back frames.
module tb_laplace_stream;

    localparam int W = 8;
    localparam int H = 8;
    localparam int P = 8;
    localparam int NOUT = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    laplace_stream_if #(.PIX_W(P)) bus ();

    laplace_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_out  = 0;
    bit rand_rdy = 1'b0;

    int exp_pix [$];
    bit exp_last[$];
    int cap     [$];
    bit capl    [$];

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference: direct kernel on the stored frame for every interior centre, raster order.
    task automatic model(input int px[$], input bit m);
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                int e, raw, v;
                e = px[r*W + c];
`ifdef LAPLACE_DIAG_EN
                raw = 8 * e;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) raw -= px[(r+dr)*W + (c+dc)];
`else
                raw = 4 * e - px[(r-1)*W + c] - px[(r+1)*W + c] - px[r*W + c - 1] - px[r*W + c + 1];
`endif
                if (raw < 0) v = m ? -raw : 0;
                else v = raw;
                if (v > 255) v = 255;
                exp_pix.push_back(v);
                exp_last.push_back((r == H - 2) && (c == W - 2));
            end
        end
    endtask

    task automatic monitor();
        bit stalled;
        logic [P-1:0] held_p;
        logic held_l;
        int ep;
        bit el;
        stalled = 1'b0;
        held_p = '0;
        held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                n_cmp++;
                if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                    n_fail++;
                    $display("FAIL in_ready: got %b, want %b", bus.in_ready, !bus.out_valid || bus.out_ready);
                end
                if (stalled) begin
                    n_cmp++;
                    if (bus.out_valid !== 1'b1 || bus.out_pixel !== held_p || bus.out_last !== held_l) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%b pix=%0d last=%b, want v=1 pix=%0d last=%b",
                                 bus.out_valid, bus.out_pixel, bus.out_last, held_p, held_l);
                    end
                end
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    n_out++;
                    cap.push_back(int'(bus.out_pixel));
                    capl.push_back(bus.out_last);
                    n_cmp++;
                    if (exp_pix.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_output: got pix %0d, want no output", bus.out_pixel);
                    end else begin
                        ep = exp_pix.pop_front();
                        el = exp_last.pop_front();
                        if (bus.out_pixel !== P'(ep) || bus.out_last !== el) begin
                            n_fail++;
                            $display("FAIL out#%0d: got pix %0d last %b, want pix %0d last %b",
                                     n_out, bus.out_pixel, bus.out_last, ep, el);
                        end
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held_p  = bus.out_pixel;
                held_l  = bus.out_last;
            end
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic send(input int px[$], input bit m, input int lat_idx);
        bit acc;
        int guard;
        for (int i = 0; i < px.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_pixel = P'(px[i]);
            bus.mode     = m;
            acc = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 200) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want acceptance", guard);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
            if (i == lat_idx - 1) check("pre_latency_out_valid", int'(bus.out_valid), 0);
            if (i == lat_idx)     check("latency_out_valid", int'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_pix.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_pending", exp_pix.size(), 0);
    endtask

    function automatic void fill(ref int q[$], input int n, input int v);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(v);
    endfunction

    initial begin
        int q[$];
        int imp[$];
        int base;
        int mbase;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;
        fork
            monitor();
            ready_gen();
        join_none

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_pixel", int'(bus.out_pixel), 0);
        check("rst_out_last",  int'(bus.out_last), 0);
        check("rst_in_ready",  int'(bus.in_ready), 1);

        // Flat frame: every interior output is 0, first output one cycle after pixel (2,2).
        fill(q, W*H, 100);
        base = n_out;
        model(q, 1'b0);
        send(q, 1'b0, 2*W + 2);
        wait_drain();
        check("flat_count", n_out - base, NOUT);
        check("flat_last_36", int'(capl[base + 35]), 1);
        check("flat_last_35", int'(capl[base + 34]), 0);

        // Impulse 200 at (3,3), mode 0. Output index of centre (r,c) is (r-1)*6+(c-1).
        fill(imp, W*H, 0);
        imp[3*W + 3] = 200;
        mbase = exp_pix.size();
        model(imp, 1'b0);
        check("model_pin_centre_m0", exp_pix[mbase + 14], 255);
        check("model_pin_up_m0", exp_pix[mbase + 8], 0);
        base = n_out;
        send(imp, 1'b0, -10);
        wait_drain();
        check("imp0_count", n_out - base, NOUT);
        check("imp0_centre", cap[base + 14], 255);
        check("imp0_up", cap[base + 8], 0);
        check("imp0_down", cap[base + 20], 0);

        // Same impulse, mode 1: direct neighbours become |-200|.
        mbase = exp_pix.size();
        model(imp, 1'b1);
        check("model_pin_left_m1", exp_pix[mbase + 13], 200);
        base = n_out;
        send(imp, 1'b1, -10);
        wait_drain();
        check("imp1_centre", cap[base + 14], 255);
        check("imp1_up", cap[base + 8], 200);
        check("imp1_left", cap[base + 13], 200);
        check("imp1_right", cap[base + 15], 200);
        check("imp1_down", cap[base + 20], 200);

        // Random backpressure on the impulse frame.
        rand_rdy = 1'b1;
        model(imp, 1'b1);
        base = n_out;
        send(imp, 1'b1, -10);
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        check("bp_count", n_out - base, NOUT);
        check("bp_up", cap[base + 8], 200);
        check("bp_down", cap[base + 20], 200);

        // Reset after 20 accepted pixels; the two results produced so far are consumed first.
        fill(q, 20, 50);
        exp_pix.push_back(0); exp_last.push_back(1'b0);
        exp_pix.push_back(0); exp_last.push_back(1'b0);
        send(q, 1'b0, -10);
        wait_drain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        fill(q, W*H, 50);
        base = n_out;
        model(q, 1'b0);
        send(q, 1'b0, 2*W + 2);
        wait_drain();
        check("midrst_count", n_out - base, NOUT);
        check("midrst_last", int'(capl[base + 35]), 1);

        // Back-to-back frames with in_valid held: flat 30, then horizontal ramp col*10.
        fill(q, W*H, 30);
        model(q, 1'b0);
        imp.delete();
        for (int i = 0; i < W*H; i++) imp.push_back((i % W) * 10);
        model(imp, 1'b0);
        for (int i = 0; i < W*H; i++) q.push_back(imp[i]);
        base = n_out;
        send(q, 1'b0, -10);
        wait_drain();
        check("b2b_count", n_out - base, 2*NOUT);
        check("b2b_last_36", int'(capl[base + 35]), 1);
        check("b2b_last_72", int'(capl[base + 71]), 1);
        check("b2b_ramp_pix", cap[base + 50], 0);

        // Small impulse 10 at (3,3), mode 1: exposes which kernel is built.
        fill(imp, W*H, 0);
        imp[3*W + 3] = 10;
        model(imp, 1'b1);
        base = n_out;
        send(imp, 1'b1, -10);
        wait_drain();
`ifdef LAPLACE_DIAG_EN
        check("diag_centre", cap[base + 14], 80);
        check("diag_ul", cap[base + 7], 10);
        check("diag_dr", cap[base + 21], 10);
`else
        check("k5_centre", cap[base + 14], 40);
        check("k5_corner", cap[base + 7], 0);
        check("k5_up", cap[base + 8], 10);
`endif

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
